// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants for the operand fetch stage: data/address widths,
// RISC-V register field positions and the hard-wired zero register.
package operand_fetch_stage_pkg;
  localparam int XLEN    = 32;
  localparam int AW      = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam logic [AW-1:0] X0 = '0;

  // Extract a register index field starting at bit lsb.
  function automatic logic [AW-1:0] reg_field(input logic [31:0] inst, input int lsb);
    return inst[lsb +: AW];
  endfunction
endpackage

// File: rtl/operand_fetch_stage_bypass.sv
// operand_bypass: picks the same-cycle writeback value over the register
// file read when the writeback targets this operand's source register.
// Ports:
//   rs_addr  in  source register index
//   rf_data  in  register file read data for rs_addr
//   wb_en/wb_rd/wb_data in  writeback port
//   operand  out bypassed operand; x0 always reads zero
module operand_bypass
  import operand_fetch_stage_pkg::*;
(
  input  logic [AW-1:0]   rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);
  always_comb begin
    operand = rf_data;
    if (rs_addr == X0)                        operand = '0;
    else if (wb_en && wb_rd == rs_addr)       operand = wb_data;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID->EX slot. Reads both source operands (with
// writeback bypass), stalls on load-use, and keeps held operands fresh by
// snooping writeback while execute back-pressures.
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   in_valid/in_ready      fetch handshake; in_pc, in_inst payload
//   rf_rs1/2_addr/data     register file read ports (addr combinational)
//   wb_en/wb_rd/wb_data    writeback port (bypass + snoop source)
//   ex_is_load/ex_rd       load in execute, for hazard detection
//   flush                  kill slot and incoming
//   out_valid/out_ready    execute handshake; out_pc/inst/rd/rs1_val/rs2_val payload
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [AW-1:0]   rf_rs1_addr,
  output logic [AW-1:0]   rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val
);
  localparam int NOPS = 2;

  logic [NOPS-1:0][AW-1:0]   rs_addr;
  logic [NOPS-1:0][XLEN-1:0] rf_data;
  logic [NOPS-1:0][XLEN-1:0] byp_val;
  logic [NOPS-1:0][AW-1:0]   held_rs;

  logic                      valid_q, valid_d;
  logic [XLEN-1:0]           pc_q, pc_d;
  logic [31:0]               inst_q, inst_d;
  logic [AW-1:0]             rd_q, rd_d;
  logic [NOPS-1:0][XLEN-1:0] val_q, val_d;

  logic hz, accept;

  assign rs_addr[0]  = reg_field(in_inst, RS1_LSB);
  assign rs_addr[1]  = reg_field(in_inst, RS2_LSB);
  assign rf_data[0]  = rf_rs1_data;
  assign rf_data[1]  = rf_rs2_data;
  assign held_rs[0]  = reg_field(inst_q, RS1_LSB);
  assign held_rs[1]  = reg_field(inst_q, RS2_LSB);
  assign rf_rs1_addr = rs_addr[0];
  assign rf_rs2_addr = rs_addr[1];

  for (genvar g = 0; g < NOPS; g++) begin : g_byp
    operand_bypass u_byp (
      .rs_addr (rs_addr[g]),
      .rf_data (rf_data[g]),
      .wb_en   (wb_en),
      .wb_rd   (wb_rd),
      .wb_data (wb_data),
      .operand (byp_val[g])
    );
  end

  // Conservative: any format that happens to encode ex_rd in a source
  // field stalls, even if that field is really an immediate.
  assign hz = in_valid && ex_is_load && (ex_rd != X0) &&
              ((ex_rd == rs_addr[0]) || (ex_rd == rs_addr[1]));

  assign in_ready = (!valid_q || out_ready) && !hz && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rd_d    = rd_q;
    val_d   = val_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      inst_d  = in_inst;
      rd_d    = reg_field(in_inst, RD_LSB);
      val_d   = byp_val;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Held slot: pick up writebacks that land after capture so the
      // operands are current when execute finally takes them.
      for (int i = 0; i < NOPS; i++)
        if (wb_en && wb_rd != X0 && wb_rd == held_rs[i]) val_d[i] = wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      rd_q    <= '0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_inst    = inst_q;
  assign out_rd      = rd_q;
  assign out_rs1_val = val_q[0];
  assign out_rs2_val = val_q[1];
endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_val, out_rs2_val;

  always #5 clock = ~clock;

  operand_fetch_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val));

  // Mock register file: x0 hard-wired to zero, written by writeback at the edge.
  logic [31:0] rf [32];
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  int checks = 0, errors = 0;

  // Reference slot: what execute should see, tracked per the stage rules.
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_rs1, m_rs2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
  endfunction

  // Value an instruction reading register r should capture this cycle.
  function automatic logic [31:0] src_val(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_inst = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk({tag, ".pc"},   out_pc, m_pc);
      chk({tag, ".inst"}, out_inst, m_inst);
      chk({tag, ".rd"},   {27'b0, out_rd}, {27'b0, m_inst[11:7]});
      chk({tag, ".rs1"},  out_rs1_val, m_rs1);
      chk({tag, ".rs2"},  out_rs2_val, m_rs2);
    end
  endtask

  // Inputs are set (after a negedge); check the combinational side, advance
  // one edge, update the reference and check the registered side.
  task automatic cycle(input string tag);
    logic [4:0] s1, s2;
    logic hz, rdy;
    logic [31:0] v1, v2;
    #1;
    s1 = in_inst[19:15];
    s2 = in_inst[24:20];
    hz  = in_valid && ex_is_load && ex_rd != 0 && (ex_rd == s1 || ex_rd == s2);
    rdy = (!m_valid || out_ready) && !hz && !flush;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
    chk({tag, ".rs1_addr"}, {27'b0, rf_rs1_addr}, {27'b0, s1});
    chk({tag, ".rs2_addr"}, {27'b0, rf_rs2_addr}, {27'b0, s2});
    v1 = src_val(s1);
    v2 = src_val(s2);
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1; m_pc = in_pc; m_inst = in_inst; m_rs1 = v1; m_rs2 = v2;
    end else if (out_ready) m_valid = 0;
    else if (m_valid && wb_en && wb_rd != 0) begin
      if (wb_rd == m_inst[19:15]) m_rs1 = wb_data;
      if (wb_rd == m_inst[24:20]) m_rs2 = wb_data;
    end
    @(posedge clock);
    if (wb_en && wb_rd != 0) rf[wb_rd] = wb_data;
    #1;
    chk_out(tag);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_inst = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    ex_is_load = 0; ex_rd = 0; flush = 0; out_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    idle_inputs();
    reset = 1;
    model_reset();
    #2;
    chk("reset.valid", {31'b0, out_valid}, 32'h0);
    chk("reset.pc", out_pc, 32'h0);
    chk("reset.rs1", out_rs1_val, 32'h0);
    @(negedge clock);
    reset = 0;

    // Writeback bypass into both operands of add x6,x5,x5.
    in_valid = 1; in_pc = 32'h100; in_inst = mk(6, 5, 5);
    wb_en = 1; wb_rd = 5; wb_data = 32'h1234;
    cycle("bypass");
    chk("bypass.rs1_const", out_rs1_val, 32'h1234);
    chk("bypass.rs2_const", out_rs2_val, 32'h1234);

    // Load-use on rs2: one stall, one bubble, then accept.
    wb_en = 0;
    ex_is_load = 1; ex_rd = 7; in_pc = 32'h104; in_inst = mk(8, 3, 7);
    cycle("hazard.stall");
    chk("hazard.bubble", {31'b0, out_valid}, 32'h0);
    ex_is_load = 0;
    cycle("hazard.accept");
    chk("hazard.accept_pc", out_pc, 32'h104);

    // Hold for 3 cycles; x9 written while held.
    in_pc = 32'h108; in_inst = mk(10, 9, 2);
    cycle("hold.load");
    out_ready = 0; in_pc = 32'h10c; in_inst = mk(11, 1, 1);
    cycle("hold.c1");
    wb_en = 1; wb_rd = 9; wb_data = 32'hDEAD;
    cycle("hold.c2");
    wb_en = 0;
    cycle("hold.c3");
    chk("hold.snoop_const", out_rs1_val, 32'hDEAD);
    chk("hold.pc_const", out_pc, 32'h108);

    // Flush with a held slot and a live incoming instruction.
    flush = 1;
    cycle("flush");
    flush = 0; in_valid = 0; out_ready = 1;
    cycle("flush.after");

    // x0 stays zero even when writeback targets x0.
    in_valid = 1; in_pc = 32'h200; in_inst = mk(4, 0, 3);
    wb_en = 1; wb_rd = 0; wb_data = 32'hFFFF;
    cycle("x0");
    chk("x0.const", out_rs1_val, 32'h0);

    // Back-to-back stream: one instruction per cycle, no bubbles.
    wb_en = 0;
    for (int i = 0; i < 8; i++) begin
      in_pc = 32'h300 + 4 * i;
      in_inst = mk(5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle("stream");
      chk("stream.pc_const", out_pc, 32'h300 + 4 * i);
    end

    // Random traffic; small register range to make hazards/bypass frequent.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_pc      = $urandom;
      in_inst    = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      wb_en      = $urandom_range(0, 1);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      ex_is_load = $urandom_range(0, 1);
      ex_rd      = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      cycle("rand");
    end

    // Reset mid-stream with a live slot: outputs clear before the next edge.
    idle_inputs();
    in_valid = 1; in_pc = 32'h400; in_inst = mk(1, 2, 3);
    cycle("midrst.load");
    chk("midrst.pre_valid", {31'b0, out_valid}, 32'h1);
    #2 reset = 1;
    #1;
    model_reset();
    chk("midrst.valid", {31'b0, out_valid}, 32'h0);
    chk("midrst.pc", out_pc, 32'h0);
    chk("midrst.inst", out_inst, 32'h0);
    chk("midrst.rd", {27'b0, out_rd}, 32'h0);
    chk("midrst.rs1", out_rs1_val, 32'h0);
    chk("midrst.rs2", out_rs2_val, 32'h0);
    @(negedge clock);
    reset = 0;
    cycle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
